trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Sequencer for synchronous exceptions, the machine external interrupt, and MRET in the 5-stage RV32 pipeline.
- Sits beside the hazard unit. Watches the EX stage (decoder flags IsMRET/IsCSR are carried into EX).
- Kills younger instructions, lets older MEM/WB instructions drain, then writes trap CSRs and redirects the PC. Only one event is in flight at a time.

Parameters:
- XLEN, 32, datapath/CSR width
- DRAIN_CYCLES, 2, cycles to wait for MEM/WB retirement before CSR update (1..7)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  EX holds a real (non-bubble) instruction
- ex_pc  in  XLEN  PC of EX instruction
- ex_illegal  in  1  EX instruction undecodable
- ex_ecall  in  1  EX instruction is ECALL
- ex_mret  in  1  EX instruction is MRET
- irq_ext  in  1  level machine external interrupt
- csr_mie  in  1  mstatus.MIE
- csr_meie  in  1  mie.MEIE
- csr_mtvec  in  XLEN  mtvec value
- csr_mepc  in  XLEN  mepc value
- stall_if  out  1  hold PC and IF/ID
- flush_if_id  out  1  bubble IF/ID
- flush_id_ex  out  1  bubble ID/EX
- flush_ex_mem  out  1  bubble EX/MEM (kills EX instruction)
- trap_we  out  1  one-cycle pulse. CSR file: mepc<=trap_mepc, mcause<=trap_mcause, MPIE<=MIE, MIE<=0
- trap_mepc  out  XLEN  captured PC
- trap_mcause  out  XLEN  captured cause
- mret_we  out  1  one-cycle pulse. CSR file: MIE<=MPIE, MPIE<=1
- redirect_valid  out  1  one-cycle PC override
- redirect_pc  out  XLEN  PC override target
- busy  out  1  FSM not IDLE

Behaviour:

States: IDLE, DRAIN, SAVE, VECTOR, RETURN.

Reset:
- State goes to IDLE.
- Drain counter, captured cause, captured PC, and the is_mret flag all clear to 0.
- All outputs are 0.
- Reset asserted mid-sequence aborts the sequence with no CSR pulse.

Trigger evaluation:
- Triggers are evaluated only in IDLE and only when ex_valid=1.
- Priority, highest first:
  1. ex_illegal: cause 2
  2. ex_ecall: cause 11
  3. irq_ext & csr_mie & csr_meie: cause 0x8000000B
  4. ex_mret
- If an interrupt and MRET coincide, the interrupt wins; mepc = PC of the MRET, and the MRET is not executed.

Trigger cycle T (Mealy):
- flush_if_id, flush_id_ex, flush_ex_mem and stall_if are asserted combinationally.
- Cause, ex_pc and is_mret are registered.
- Counter loads DRAIN_CYCLES-1; state goes to DRAIN.

DRAIN:
- stall_if and all three flushes stay asserted.
- Counter decrements each cycle. When it reaches 0, go to RETURN if is_mret, otherwise SAVE.

SAVE (1 cycle):
- trap_we=1, stall_if=1; then go to VECTOR.

VECTOR (1 cycle):
- redirect_valid=1; then go to IDLE.
- redirect_pc:
  - csr_mtvec[1:0]==01 and interrupt: {mtvec[XLEN-1:2],2'b00} + 4*(cause[4:0]).
  - Otherwise: {mtvec[XLEN-1:2],2'b00}.
- stall_if=0, so the fetch at the target proceeds.

RETURN (1 cycle):
- mret_we=1, redirect_valid=1, redirect_pc = {csr_mepc[XLEN-1:2],2'b00}; then go to IDLE.

Resulting timing:
- Exception/IRQ with DRAIN_CYCLES=2: T detect, T+1..T+2 DRAIN, T+3 SAVE, T+4 VECTOR, T+5 IDLE.
- MRET: redirect at T+3.

Other rules:
- busy = (state != IDLE), registered.
- Triggers arriving while busy are ignored. The flushes keep EX empty, and a level IRQ is re-evaluated once IDLE.
- trap_mepc and trap_mcause are driven from the capture registers in every state.
- irq_ext deasserting after T does not abort the sequence.
- Vector address arithmetic is modulo 2^XLEN (wrap-around allowed).
- An ex_valid=0 bubble never triggers, even if the flags are X/1.

Decomposition:
- Shared package trap_pkg holds:
  - cause constants CAUSE_ILLEGAL=2, CAUSE_ECALL=11, CAUSE_MEI=32'h8000000B
  - MTVEC_MODE_VECTORED=2'b01
  - the state enum encoding
- No sub-module; the cause priority encoder is inline combinational logic.

Test Plan:
- ECALL at ex_pc=0x100, mtvec=0x200, DRAIN_CYCLES=2 -> flushes at T; trap_we at T+3 with mepc=0x100, mcause=11; redirect_pc=0x200 at T+4; busy T+1..T+4.
- irq_ext=1, MIE=MEIE=1, ex_pc=0x144, mtvec=0x201 -> mcause=0x8000000B, redirect_pc=0x22C; irq_ext=1 with MIE=0 -> no action.
- ex_illegal and ex_ecall both set at pc 0x80 -> mcause=2 only, single trap_we pulse.
- MRET at 0x300, csr_mepc=0x104 -> no trap_we; mret_we and redirect 0x104 at T+3; same cycle with pending enabled IRQ -> trap taken, mepc=0x300.
- Second ECALL presented at T+1 while busy -> ignored, exactly one trap_we; ex_valid=0 with ex_ecall=1 -> no trigger.
- rst asserted at T+2 (DRAIN) -> all outputs 0 immediately, no trap_we/redirect afterwards, next ECALL handled normally.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared definitions for the trap/MRET sequencer: cause codes, mtvec mode and FSM encoding.
package trap_pkg;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StDrain  = 3'd1,
        StSave   = 3'd2,
        StVector = 3'd3,
        StReturn = 3'd4
    } trap_state_e;

endpackage

// File: rtl/trap_ctrl.sv
// Trap/MRET sequencer: kills younger instructions, drains MEM/WB, then updates
// trap CSRs and redirects fetch. One event in flight at a time.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_illegal,
    input  logic            ex_ecall,
    input  logic            ex_mret,
    input  logic            irq_ext,
    input  logic            csr_mie,
    input  logic            csr_meie,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic            stall_if,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            flush_ex_mem,
    output logic            trap_we,
    output logic [XLEN-1:0] trap_mepc,
    output logic [XLEN-1:0] trap_mcause,
    output logic            mret_we,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    localparam int unsigned CNT_W = 3;
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    trap_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            is_mret_q, is_mret_d;
    logic            busy_q;

    logic            irq_pending;
    logic            take;
    logic            take_mret;
    logic [XLEN-1:0] take_cause;
    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] vec_off;
    logic [XLEN-1:0] vec_pc;

    assign irq_pending = irq_ext & csr_mie & csr_meie;

    // Priority encoder; a bubble never triggers regardless of its flags.
    always_comb begin
        take       = 1'b0;
        take_mret  = 1'b0;
        take_cause = '0;
        if (!rst && state_q == StIdle && ex_valid) begin
            if (ex_illegal) begin
                take       = 1'b1;
                take_cause = XLEN'(CAUSE_ILLEGAL);
            end else if (ex_ecall) begin
                take       = 1'b1;
                take_cause = XLEN'(CAUSE_ECALL);
            end else if (irq_pending) begin
                take       = 1'b1;
                take_cause = XLEN'(CAUSE_MEI);
            end else if (ex_mret) begin
                take      = 1'b1;
                take_mret = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cause_q   <= '0;
            pc_q      <= '0;
            is_mret_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            pc_q      <= pc_d;
            is_mret_q <= is_mret_d;
            busy_q    <= (state_d != StIdle);
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        pc_d      = pc_q;
        is_mret_d = is_mret_q;
        unique case (state_q)
            StIdle: begin
                if (take) begin
                    state_d   = StDrain;
                    cnt_d     = CNT_W'(DRAIN_CYCLES - 1);
                    cause_d   = take_cause;
                    pc_d      = ex_pc;
                    is_mret_d = take_mret;
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    state_d = is_mret_q ? StReturn : StSave;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSave:   state_d = StVector;
            StVector: state_d = StIdle;
            StReturn: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Vectored mode offsets by 4*cause only for interrupts; wraps modulo 2^XLEN.
    assign vec_base = csr_mtvec & ALIGN_MASK;
    assign vec_off  = {{(XLEN-7){1'b0}}, cause_q[4:0], 2'b00};
    assign vec_pc   = ((csr_mtvec[1:0] == MTVEC_MODE_VECTORED) && cause_q[XLEN-1])
                    ? vec_base + vec_off : vec_base;

    // Output logic
    always_comb begin
        stall_if       = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        flush_ex_mem   = 1'b0;
        trap_we        = 1'b0;
        mret_we        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        unique case (state_q)
            StIdle: begin
                if (take) begin
                    stall_if     = 1'b1;
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                end
            end
            StDrain: begin
                stall_if     = 1'b1;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end
            StSave: begin
                trap_we  = 1'b1;
                stall_if = 1'b1;
            end
            StVector: begin
                redirect_valid = 1'b1;
                redirect_pc    = vec_pc;
            end
            StReturn: begin
                mret_we        = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = csr_mepc & ALIGN_MASK;
            end
            default: ;
        endcase
    end

    assign trap_mepc   = pc_q;
    assign trap_mcause = cause_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: a scoreboard of expected CSR pulses and
// redirects (kind, cycle, values) is filled at stimulus time and drained by a monitor.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_illegal = 1'b0;
    logic        ex_ecall = 1'b0;
    logic        ex_mret = 1'b0;
    logic        irq_ext = 1'b0;
    logic        csr_mie = 1'b0;
    logic        csr_meie = 1'b0;
    logic [31:0] csr_mtvec = '0;
    logic [31:0] csr_mepc = '0;
    logic        stall_if, flush_if_id, flush_id_ex, flush_ex_mem;
    logic        trap_we, mret_we, redirect_valid, busy;
    logic [31:0] trap_mepc, trap_mcause, redirect_pc;

    localparam int KTrap = 0;
    localparam int KMret = 1;
    localparam int KRedir = 2;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;

    trap_ctrl #(.XLEN(32), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_illegal(ex_illegal), .ex_ecall(ex_ecall), .ex_mret(ex_mret),
        .irq_ext(irq_ext), .csr_mie(csr_mie), .csr_meie(csr_meie),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .stall_if(stall_if), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem), .trap_we(trap_we), .trap_mepc(trap_mepc),
        .trap_mcause(trap_mcause), .mret_we(mret_we), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the head of the scoreboard in kind, cycle and value.
    always @(negedge clk) begin : mon
        logic        act;
        logic [31:0] oa, ob;
        ev_t         e;
        for (int k = 0; k < 3; k++) begin
            act = 1'b0; oa = '0; ob = '0;
            case (k)
                KTrap:   begin act = trap_we; oa = trap_mepc; ob = trap_mcause; end
                KMret:   act = mret_we;
                default: begin act = redirect_valid; oa = redirect_pc; end
            endcase
            if (act === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event kind=%0d cyc=%0d a=%h b=%h", k, cyc, oa, ob);
                end else begin
                    e = sb.pop_front();
                    if (e.kind !== k || e.cyc !== cyc || e.a !== oa || e.b !== ob) begin
                        bad++;
                        $display("FAIL event got kind=%0d cyc=%0d a=%h b=%h want kind=%0d cyc=%0d a=%h b=%h",
                                 k, cyc, oa, ob, e.kind, e.cyc, e.a, e.b);
                    end
                end
            end
        end
    end

    task automatic drive_ex(input logic v, input logic [31:0] pc, input logic ill,
                            input logic ec, input logic mr);
        @(posedge clk); #1;
        ex_valid = v; ex_pc = pc; ex_illegal = ill; ex_ecall = ec; ex_mret = mr;
    endtask

    task automatic idle_ex();
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_illegal = 1'b0; ex_ecall = 1'b0; ex_mret = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({stall_if, flush_if_id, flush_id_ex, flush_ex_mem, trap_we, mret_we,
             redirect_valid, busy} !== 8'h00 || trap_mepc !== 0 || trap_mcause !== 0 ||
            redirect_pc !== 0) begin
            bad++;
            $display("FAIL reset_outputs ctl=%b mepc=%h mcause=%h rpc=%h want all zero",
                     {stall_if, flush_if_id, flush_id_ex, flush_ex_mem, trap_we, mret_we,
                      redirect_valid, busy}, trap_mepc, trap_mcause, redirect_pc);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_ecall();
        int t;
        csr_mtvec = 32'h200;
        drive_ex(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
        t = cyc;
        sb.push_back('{KTrap, t + 3, 32'h100, 32'd11});
        sb.push_back('{KRedir, t + 4, 32'h200, 32'h0});
        @(negedge clk);
        total++;
        if ({stall_if, flush_if_id, flush_id_ex, flush_ex_mem, busy} !== 5'b11110) begin
            bad++;
            $display("FAIL ecall_trigger_cycle got=%b want=11110",
                     {stall_if, flush_if_id, flush_id_ex, flush_ex_mem, busy});
        end
        idle_ex();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            total++;
            if (busy !== (i <= 4)) begin
                bad++;
                $display("FAIL ecall_busy T+%0d got=%b want=%b", i, busy, (i <= 4));
            end
        end
        settle(3);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL ecall_pending got=%0d want=0", sb.size());
        end
    endtask

    task automatic test_irq();
        int t;
        csr_mie = 1'b1; csr_meie = 1'b1; csr_mtvec = 32'h201; irq_ext = 1'b1;
        drive_ex(1'b1, 32'h144, 1'b0, 1'b0, 1'b0);
        t = cyc;
        sb.push_back('{KTrap, t + 3, 32'h144, 32'h8000_000B});
        sb.push_back('{KRedir, t + 4, 32'h22C, 32'h0});
        idle_ex();
        irq_ext = 1'b0;
        settle(6);
        total++;
        if (sb.size() != 0 || trap_mcause !== 32'h8000_000B) begin
            bad++;
            $display("FAIL irq_vectored pending=%0d mcause=%h want 0 and 8000000b",
                     sb.size(), trap_mcause);
        end
        csr_mie = 1'b0; irq_ext = 1'b1;
        drive_ex(1'b1, 32'h150, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if ({stall_if, flush_ex_mem} !== 2'b00) begin
            bad++;
            $display("FAIL irq_masked_flush got=%b want=00", {stall_if, flush_ex_mem});
        end
        idle_ex();
        irq_ext = 1'b0; csr_mie = 1'b1;
        settle(6);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL irq_masked_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_priority();
        int t;
        csr_mtvec = 32'h200;
        drive_ex(1'b1, 32'h80, 1'b1, 1'b1, 1'b0);
        t = cyc;
        sb.push_back('{KTrap, t + 3, 32'h80, 32'd2});
        sb.push_back('{KRedir, t + 4, 32'h200, 32'h0});
        idle_ex();
        settle(6);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL priority_pending got=%0d want=0", sb.size());
        end
    endtask

    task automatic test_mret();
        int t;
        csr_mepc = 32'h107;
        drive_ex(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        t = cyc;
        sb.push_back('{KMret, t + 3, 32'h0, 32'h0});
        sb.push_back('{KRedir, t + 3, 32'h104, 32'h0});
        idle_ex();
        settle(6);
        total++;
        if (sb.size() != 0 || trap_mepc !== 32'h300) begin
            bad++;
            $display("FAIL mret pending=%0d mepc=%h want 0 and 300", sb.size(), trap_mepc);
        end
        csr_mie = 1'b1; csr_meie = 1'b1; csr_mtvec = 32'h200; irq_ext = 1'b1;
        drive_ex(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        t = cyc;
        sb.push_back('{KTrap, t + 3, 32'h300, 32'h8000_000B});
        sb.push_back('{KRedir, t + 4, 32'h200, 32'h0});
        idle_ex();
        irq_ext = 1'b0;
        settle(6);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL mret_vs_irq_pending got=%0d want=0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int t;
        csr_mtvec = 32'h200;
        drive_ex(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
        t = cyc;
        sb.push_back('{KTrap, t + 3, 32'h100, 32'd11});
        sb.push_back('{KRedir, t + 4, 32'h200, 32'h0});
        for (int k = 1; k <= 4; k++) begin
            drive_ex(1'b1, 32'h104, 1'b0, 1'b1, 1'b0);
            if (k == 1) begin
                @(negedge clk);
                total++;
                if ({stall_if, flush_ex_mem, busy} !== 3'b111 || trap_mepc !== 32'h100) begin
                    bad++;
                    $display("FAIL busy_ignore got=%b mepc=%h want=111 mepc=100",
                             {stall_if, flush_ex_mem, busy}, trap_mepc);
                end
            end
        end
        idle_ex();
        settle(4);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL back_to_back_pending got=%0d want=0", sb.size());
        end
        drive_ex(1'b0, 32'h200, 1'bx, 1'b1, 1'b1);
        @(negedge clk);
        total++;
        if ({stall_if, flush_if_id, flush_id_ex, flush_ex_mem} !== 4'b0000) begin
            bad++;
            $display("FAIL bubble_trigger got=%b want=0000",
                     {stall_if, flush_if_id, flush_id_ex, flush_ex_mem});
        end
        idle_ex();
        settle(6);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL bubble_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        csr_mtvec = 32'h200;
        drive_ex(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
        idle_ex();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++;
        if ({stall_if, flush_if_id, flush_id_ex, flush_ex_mem, trap_we, mret_we,
             redirect_valid, busy} !== 8'h00 || trap_mepc !== 0 || trap_mcause !== 0) begin
            bad++;
            $display("FAIL reset_mid ctl=%b mepc=%h mcause=%h want all zero",
                     {stall_if, flush_if_id, flush_id_ex, flush_ex_mem, trap_we, mret_we,
                      redirect_valid, busy}, trap_mepc, trap_mcause);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        settle(6);
        drive_ex(1'b1, 32'h120, 1'b0, 1'b1, 1'b0);
        t = cyc;
        sb.push_back('{KTrap, t + 3, 32'h120, 32'd11});
        sb.push_back('{KRedir, t + 4, 32'h200, 32'h0});
        idle_ex();
        settle(6);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL reset_recover_pending got=%0d want=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_irq();
        test_priority();
        test_mret();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
